// File: rtl/encoder32to5_seq_if.sv
// Handshake bundle for the sequential vector-to-index encoder.
// The master side produces vectors and consumes indices; the slave side is the encoder.
interface encoder32to5_seq_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] Data_in;
  logic             Out_valid;
  logic             Out_ready;
  logic [IDX_W-1:0] Data_out;
  logic             Out_last;
  logic             Out_zero;

  modport master (
    output In_valid, Data_in, Out_ready,
    input  In_ready, Out_valid, Data_out, Out_last, Out_zero
  );

  modport slave (
    input  In_valid, Data_in, Out_ready,
    output In_ready, Out_valid, Data_out, Out_last, Out_zero
  );
endinterface

// File: rtl/encoder32to5_seq.sv
// Sequential WIDTH-to-IDX_W encoder: accepts a vector, then emits the index of
// every set bit, one per output handshake. An all-zero vector yields a single
// beat flagged with Out_zero.
// Optional macro ENC_MSB_FIRST_EN: emit indices highest-first instead of lowest-first.
module encoder32to5_seq #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  encoder32to5_seq_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] pending_reg;
  logic             zero_flag_reg;
  logic             armed_reg;

  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_onehot;
  logic             single_bit;
  logic             accept;
  logic             emit;

  logic             in_ready;
  logic             out_valid;
  logic [IDX_W-1:0] data_out;
  logic             out_last;
  logic             out_zero;

`ifdef ENC_MSB_FIRST_EN
  // Pick the highest set bit of the pending vector (later iterations win).
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_reg[i]) sel_idx = IDX_W'(i);
    end
  end
`else
  // Pick the lowest set bit of the pending vector (later iterations win).
  always_comb begin
    sel_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_reg[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  // One-hot mask of the bit being emitted, used to retire it from pending.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
      assign sel_onehot[gi] = (sel_idx == IDX_W'(gi));
    end
  endgenerate

  // At most one bit left means the current beat is the final one.
  assign single_bit = ((pending_reg & (pending_reg - WIDTH'(1))) == '0);
  assign accept     = bus.In_valid & in_ready;
  assign emit       = out_valid & bus.Out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: IDLE waits for a vector, SCAN runs until the last beat is taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (emit && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from registered state only; Data_out is forced to 0 outside SCAN.
  always_comb begin
    in_ready  = (state_reg == IDLE) && armed_reg;
    out_valid = 1'b0;
    data_out  = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    if (state_reg == SCAN) begin
      out_valid = 1'b1;
      data_out  = sel_idx;
      out_last  = single_bit;
      out_zero  = zero_flag_reg;
    end
  end

  // Datapath: capture the vector on accept, clear one bit per emitted beat.
  // armed_reg holds In_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      zero_flag_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
      if (accept) begin
        pending_reg   <= bus.Data_in;
        zero_flag_reg <= (bus.Data_in == '0);
      end else if (emit) begin
        pending_reg <= pending_reg & ~sel_onehot;
      end
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = out_valid;
  assign bus.Data_out  = data_out;
  assign bus.Out_last  = out_last;
  assign bus.Out_zero  = out_zero;
endmodule

// File: tb/tb_encoder32to5_seq.sv
// Self-checking bench for encoder32to5_seq: directed scenarios followed by
// random vectors with random back-pressure, checked against a bit-list model.
module tb_encoder32to5_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  encoder32to5_seq_if #(.WIDTH(WIDTH)) bus ();

  encoder32to5_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef int idx_q_t[$];

  // Expected beat sequence: list of set-bit positions in emission order,
  // or a single index 0 for an empty vector.
  function automatic idx_q_t expected_beats(input logic [31:0] v);
    idx_q_t q;
    if (v == 32'd0) begin
      q.push_back(0);
      return q;
    end
    for (int b = 0; b < 32; b++) begin
      if (v[b]) begin
`ifdef ENC_MSB_FIRST_EN
        q.push_front(b);
`else
        q.push_back(b);
`endif
      end
    end
    return q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge: sample outputs and drive inputs here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one vector and consume all of its beats, checking every cycle.
  task automatic send_vector(input logic [31:0] v, input int stall_pct,
                             input int stall_first, input bit poke);
    idx_q_t exp_q;
    int     n;
    int     stalls;
    int     beats;
    int     cycles;
    exp_q  = expected_beats(v);
    n      = 0;
    stalls = 0;
    beats  = 0;
    cycles = 0;
    while (bus.In_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, bus.In_ready}, 32'd1);
    bus.Data_in   = v;
    bus.In_valid  = 1'b1;
    bus.Out_ready = 1'b0;
    tick();
    bus.In_valid = 1'b0;
    chk("latency_valid", {31'd0, bus.Out_valid}, 32'd1);
    while (exp_q.size() > 0 && cycles < 200) begin
      cycles++;
      chk("out_valid", {31'd0, bus.Out_valid}, 32'd1);
      chk("in_ready_busy", {31'd0, bus.In_ready}, 32'd0);
      chk("data_out", {27'd0, bus.Data_out}, exp_q[0]);
      chk("out_last", {31'd0, bus.Out_last}, {31'd0, exp_q.size() == 1});
      chk("out_zero", {31'd0, bus.Out_zero}, {31'd0, v == 32'd0});
      if (poke) begin
        bus.In_valid = (exp_q.size() > 1);
        bus.Data_in  = ~v;
      end
      if (stall_first > 0) begin
        bus.Out_ready = 1'b0;
        stall_first--;
      end else if (stalls < 4 && $urandom_range(99) < stall_pct) begin
        bus.Out_ready = 1'b0;
        stalls++;
      end else begin
        bus.Out_ready = 1'b1;
        stalls = 0;
        void'(exp_q.pop_front());
        beats++;
      end
      tick();
    end
    chk("beats_left", exp_q.size(), 32'd0);
    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b0;
    chk("idle_valid", {31'd0, bus.Out_valid}, 32'd0);
    chk("idle_ready", {31'd0, bus.In_ready}, 32'd1);
    $display("[TB] vector %08h beats %0d", v, beats);
  endtask

  initial begin
    logic [31:0] v;
    rst_n         = 1'b0;
    bus.In_valid  = 1'b0;
    bus.Data_in   = '0;
    bus.Out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.In_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.Out_valid}, 32'd0);
    chk("rst_data_out", {27'd0, bus.Data_out}, 32'd0);
    chk("rst_out_last", {31'd0, bus.Out_last}, 32'd0);
    chk("rst_out_zero", {31'd0, bus.Out_zero}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'd0, bus.In_ready}, 32'd1);

    // Directed scenarios.
    send_vector(32'h0000_0001, 0, 0, 1'b0);
    send_vector(32'h8000_0011, 0, 0, 1'b0);
    send_vector(32'h0000_0000, 0, 0, 1'b0);
    send_vector(32'h0000_0006, 0, 5, 1'b0);
    send_vector(32'hFFFF_FFFF, 0, 0, 1'b1);

    // Reset in the middle of a scan discards the remaining beats.
    bus.Data_in  = 32'h0000_00F0;
    bus.In_valid = 1'b1;
    tick();
    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b1;
    chk("mid_first_beat", {27'd0, bus.Data_out}, 32'd4);
    tick();
    chk("mid_second_beat", {27'd0, bus.Data_out}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.Out_valid}, 32'd0);
    chk("mid_rst_data", {27'd0, bus.Data_out}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.In_ready}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", {31'd0, bus.In_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("mid_no_beats", {31'd0, bus.Out_valid}, 32'd0);
      tick();
    end
    bus.Out_ready = 1'b0;
    $display("[TB] vector 000000f0 aborted by reset");

    // Random vectors with random back-pressure.
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(3))
        0:       v = $urandom;
        1:       v = $urandom & $urandom & $urandom;
        2:       v = 32'd1 << $urandom_range(31);
        default: v = ($urandom_range(1) == 0) ? 32'd0 : ($urandom | 32'h8000_0001);
      endcase
      send_vector(v, 30, 0, 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/encoder32to5_seq.md
Name: encoder32to5_seq

Overview:
Sequential 32-to-5 encoder, the inverse of the team's 5x32 decoder. Accepts a 32-bit vector over a valid/ready handshake. Emits the 5-bit index of every set bit, one index per output handshake, lowest bit first. Sits downstream of request/one-hot producers and converts their vectors back to binary indices for decoder-side consumers.

Parameters:
WIDTH, 32, input vector width; must be a power of 2, from 2 to 32.
IDX_W, $clog2(WIDTH) = 5, index width; derived, never overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous reset, active-low.
In_valid  input  1  Data_in is valid this cycle.
In_ready  output  1  block can accept a vector.
Data_in  input  WIDTH  vector to encode.
Out_valid  output  1  Data_out is valid this cycle.
Out_ready  input  1  consumer accepts Data_out.
Data_out  output  IDX_W  index of the current set bit.
Out_last  output  1  current beat is the final beat for this vector.
Out_zero  output  1  the accepted vector was all-zero.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE, pending=0.
  - In_ready=0 while rst_n=0; In_ready=1 from the first clock after release.
  - Out_valid=0, Data_out=0, Out_last=0, Out_zero=0.
- Reset mid-scan discards the pending vector. No further beats are emitted for it.
- States: IDLE and SCAN.
- IDLE:
  - In_ready=1, Out_valid=0.
  - On In_valid & In_ready: pending <= Data_in, zero_flag <= (Data_in==0), go to SCAN.
- SCAN:
  - In_ready=0, Out_valid=1.
  - Data_out = index of the lowest set bit of pending.
  - Out_last = 1 when pending has at most one bit set.
  - Out_zero = zero_flag.
- Output handshake (Out_valid & Out_ready):
  - Clear the emitted bit in pending.
  - If Out_last=1, go to IDLE.
- All-zero vector: exactly one beat with Data_out=0, Out_zero=1, Out_last=1.
- Non-zero vector: Out_zero=0 on all beats; the beat count equals popcount(Data_in).
- Latency: input handshake in cycle N gives Out_valid=1 in cycle N+1.
- Throughput: one beat per cycle while Out_ready=1, then one IDLE cycle before the next vector can be accepted.
- Back-pressure: while Out_valid=1 and Out_ready=0, Data_out, Out_last and Out_zero hold stable.
- In_valid while In_ready=0 is ignored. The source must hold Data_in until it is accepted.
- Outputs are functions of registered state only. There is no combinational path from any input to any output.
- Index arithmetic is unsigned IDX_W bits. Bit WIDTH-1 maps to index WIDTH-1 (31) with no wrap.

Optional Feature:
ENC_MSB_FIRST_EN:
- Defined: SCAN selects the highest set bit of pending instead of the lowest, so indices are emitted in descending order. Out_last, Out_zero and the handshake rules are unchanged.
- Undefined: lowest-first order as specified above.

Test Plan:
1. Data_in=32'h0000_0001, Out_ready=1 -> one beat: Data_out=0, Out_last=1, Out_zero=0. In_ready=1 on the following cycle.
2. Data_in=32'h8000_0011, Out_ready=1 -> beats Data_out=0, 4, 31 on three consecutive cycles; Out_last=1 only on 31. With ENC_MSB_FIRST_EN the order is 31, 4, 0, with Out_last on 0.
3. Data_in=32'h0000_0000 -> one beat: Data_out=0, Out_zero=1, Out_last=1.
4. Data_in=32'h0000_0006 with Out_ready=0 for 5 cycles -> Data_out holds 1 and Out_valid=1 throughout. After Out_ready=1, beats 1 then 2 (Out_last on 2).
5. Data_in=32'hFFFF_FFFF, Out_ready=1 -> 32 consecutive beats 0..31 with In_ready=0 throughout. In_ready=1 the cycle after beat 31. A second In_valid during the scan is not accepted.
6. rst_n=0 asserted mid-scan of 32'h0000_00F0 after beat 4 -> Out_valid=0 and Data_out=0 immediately. After release: In_ready=1, and no beats 5-7 are emitted.
